serial_display_rx: RTL and testbench

SERIAL_DISPLAY_RX -- requirements
Module: serial_display_rx

---
 rtl/serial_display_rx.sv | 207 ++++++++++++++++++++
 tb/tb_serial_display_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_display_rx.sv
// serial_display_rx
// Receives a 48-bit display frame over a three-wire serial link
// (shift clock, data, latch). None of the three wires is related to i_clk.
// Each wire goes through a synchronizer. Shift-clock and latch rising edges
// are then detected in the i_clk domain. Bits are shifted MSB first into
// six byte slots. A latch edge commits the frame only when exactly 48 bits
// have arrived. Any other latch edge reports a framing error.
// A frame that stalls mid-way is aborted after TIMEOUT_CYCLES.

module serial_display_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_sdata,
    input  logic        i_latch,
    output logic [47:0] o_frame,
    output logic        o_valid,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int FRAME_BITS = 48;
    // Edge detection stays masked until the synchronizer and the edge flop
    // both hold genuine samples taken after reset release.
    localparam int SETTLE_MAX = SYNC_STAGES + 1;
    localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);
    localparam int IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        OVERFLOW = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] sdata_sync_r;
    logic [SYNC_STAGES-1:0] latch_sync_r;
    logic                   sclk_prev_r;
    logic                   latch_prev_r;
    logic [SETTLE_W-1:0]    settle_cnt_r;

    logic edge_ready_s;
    logic sclk_rise_s;
    logic latch_rise_s;
    logic sdata_bit_s;

    // Synchronizer chains, edge-detect history and post-reset settle counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sclk_sync_r  <= {SYNC_STAGES{1'b0}};
            sdata_sync_r <= {SYNC_STAGES{1'b0}};
            latch_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_prev_r  <= 1'b0;
            latch_prev_r <= 1'b0;
            settle_cnt_r <= {SETTLE_W{1'b0}};
        end else begin
            sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], i_sclk};
            sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], i_sdata};
            latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], i_latch};
            sclk_prev_r  <= sclk_sync_r[SYNC_STAGES-1];
            latch_prev_r <= latch_sync_r[SYNC_STAGES-1];
            if (settle_cnt_r != SETTLE_W'(SETTLE_MAX)) begin
                settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
        end
    end

    // A line held high through reset release looks like 0 -> 1 in the chain.
    // Masking edges until the chain is settled keeps that from becoming an edge.
    assign edge_ready_s = (settle_cnt_r == SETTLE_W'(SETTLE_MAX));
    assign sclk_rise_s  = edge_ready_s & sclk_sync_r[SYNC_STAGES-1] & ~sclk_prev_r;
    assign latch_rise_s = edge_ready_s & latch_sync_r[SYNC_STAGES-1] & ~latch_prev_r;
    assign sdata_bit_s  = sdata_sync_r[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t           state_r;
    logic [5:0]       bit_cnt_r;
    logic [2:0]       byte_cnt_r;
    logic [7:0]       shift_r;
    logic [5:0][7:0]  slots_r;
    logic [IDLE_W-1:0] idle_cnt_r;

    // The sclk step is computed first. A latch edge in the same cycle is
    // then judged on the updated count, state and slots.
    state_t          step_state_s;
    logic [5:0]      step_bits_s;
    logic [2:0]      step_bytes_s;
    logic [7:0]      step_shift_s;
    logic [7:0]      step_byte_s;
    logic [5:0][7:0] step_slots_s;
    logic            frame_ok_s;
    logic            timeout_s;

    // Effect of a detected sclk edge on the receive state (identity otherwise)
    always_comb begin
        step_state_s = state_r;
        step_bits_s  = bit_cnt_r;
        step_bytes_s = byte_cnt_r;
        step_shift_s = shift_r;
        step_slots_s = slots_r;
        step_byte_s  = {shift_r[6:0], sdata_bit_s};
        if (sclk_rise_s) begin
            case (state_r)
                IDLE, RECV: begin
                    if (bit_cnt_r == 6'(FRAME_BITS)) begin
                        // A 49th bit: the frame is now too long.
                        step_state_s = OVERFLOW;
                    end else begin
                        step_state_s = RECV;
                        step_shift_s = step_byte_s;
                        step_bits_s  = bit_cnt_r + 6'd1;
                        if (bit_cnt_r[2:0] == 3'd7) begin
                            step_slots_s[byte_cnt_r] = step_byte_s;
                            step_bytes_s             = byte_cnt_r + 3'd1;
                        end else begin
                            step_bytes_s = byte_cnt_r;
                        end
                    end
                end
                OVERFLOW: begin
                    // Extra bits are dropped, and the slots keep the first 48.
                    step_state_s = OVERFLOW;
                end
                default: begin
                    step_state_s = IDLE;
                end
            endcase
        end else begin
            step_state_s = state_r;
        end
    end

    assign frame_ok_s = (step_state_s == RECV) && (step_bits_s == 6'(FRAME_BITS));
    assign timeout_s  = (idle_cnt_r == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Receive FSM: latch commit/reject, sclk shifting, stall timeout, outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 6'd0;
            byte_cnt_r  <= 3'd0;
            shift_r     <= 8'h00;
            slots_r     <= 48'h0;
            idle_cnt_r  <= {IDLE_W{1'b0}};
            o_frame     <= 48'h0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            if (latch_rise_s) begin
                // Every latch ends the frame. Only an exact 48-bit RECV frame
                // is published.
                slots_r <= step_slots_s;
                if (frame_ok_s) begin
                    o_frame <= step_slots_s;
                    o_valid <= 1'b1;
                end else begin
                    o_frame_err <= 1'b1;
                end
                state_r    <= IDLE;
                bit_cnt_r  <= 6'd0;
                byte_cnt_r <= 3'd0;
                shift_r    <= 8'h00;
                idle_cnt_r <= {IDLE_W{1'b0}};
                o_busy     <= 1'b0;
            end else if (sclk_rise_s) begin
                state_r    <= step_state_s;
                bit_cnt_r  <= step_bits_s;
                byte_cnt_r <= step_bytes_s;
                shift_r    <= step_shift_s;
                slots_r    <= step_slots_s;
                idle_cnt_r <= {IDLE_W{1'b0}};
                o_busy     <= 1'b1;
            end else if (state_r != IDLE) begin
                if (timeout_s) begin
                    // The sender went quiet mid-frame: drop the partial frame.
                    state_r     <= IDLE;
                    bit_cnt_r   <= 6'd0;
                    byte_cnt_r  <= 3'd0;
                    shift_r     <= 8'h00;
                    idle_cnt_r  <= {IDLE_W{1'b0}};
                    o_frame_err <= 1'b1;
                    o_busy      <= 1'b0;
                end else begin
                    idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                    o_busy     <= 1'b1;
                end
            end else begin
                idle_cnt_r <= {IDLE_W{1'b0}};
                o_busy     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_display_rx.sv
// Testbench for serial_display_rx. It drives the serial link with randomized
// bits and checks the DUT against a queue-based reference model. The model
// turns a bit stream into a frame, or into an error, by counting bits.
module tb_serial_display_rx;

    localparam int SYNC = 2;
    localparam int TO   = 64;

    logic        i_clk   = 1'b0;
    logic        i_rst   = 1'b0;
    logic        i_sclk  = 1'b0;
    logic        i_sdata = 1'b0;
    logic        i_latch = 1'b0;
    logic [47:0] o_frame;
    logic        o_valid;
    logic        o_frame_err;
    logic        o_busy;

    int n_checks      = 0;
    int n_fail        = 0;
    int cyc           = 0;
    int valid_cnt     = 0;
    int err_cnt       = 0;
    int both_cnt      = 0;
    int last_rise_cyc = 0;

    bit          sent_q[$];
    logic [47:0] model_frame = 48'h0;

    serial_display_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sclk      (i_sclk),
        .i_sdata     (i_sdata),
        .i_latch     (i_latch),
        .o_frame     (o_frame),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Pulse observer: counts output pulses once per cycle, away from the active edge
    always @(negedge i_clk) begin
        cyc++;
        if (o_valid) valid_cnt++;
        if (o_frame_err) err_cnt++;
        if (o_valid && o_frame_err) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic send_bit(input bit b);
        i_sdata = b;
        tick(3);
        i_sclk = 1'b1;
        last_rise_cyc = cyc;
        tick(4);
        i_sclk = 1'b0;
        tick(3);
        sent_q.push_back(b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_random_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)));
    endtask

    task automatic pulse_latch();
        i_latch = 1'b1;
        tick(5);
        i_latch = 1'b0;
        tick(5);
    endtask

    // Reference model of a latch: exactly 48 bits give a frame whose byte k
    // holds bits 8k..8k+7, first bit as MSB. Any other count is rejected and
    // the frame is kept.
    task automatic model_latch(output bit ok);
        logic [47:0] f;
        f = 48'h0;
        ok = (sent_q.size() == 48);
        if (ok) begin
            for (int i = 0; i < 48; i++) f[(i / 8) * 8 + (7 - (i % 8))] = sent_q[i];
            model_frame = f;
        end
        sent_q.delete();
    endtask

    task automatic test_reset();
        tick(4);
        n_checks++; if (o_frame !== 48'h0) begin n_fail++; $display("FAIL reset_frame: got %h want %h", o_frame, 48'h0); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_frame_err); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        i_rst = 1'b1;
        tick(8);
    endtask

    task automatic test_good_frame();
        int v0, e0;
        bit ok;
        logic [7:0] bytes [6];
        bytes = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
        v0 = valid_cnt; e0 = err_cnt;
        for (int k = 0; k < 6; k++) send_byte(bytes[k]);
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_mid: got %b want 1", o_busy); end
        pulse_latch();
        model_latch(ok);
        n_checks++; if (o_frame !== 48'h6D664F5B063F) begin n_fail++; $display("FAIL good_frame: got %h want %h", o_frame, 48'h6D664F5B063F); end
        n_checks++; if (o_frame !== model_frame) begin n_fail++; $display("FAIL good_frame_model: got %h want %h", o_frame, model_frame); end
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL good_valid: got %0d pulses want 1", valid_cnt - v0); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL good_err: got %0d pulses want 0", err_cnt - e0); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_after: got %b want 0", o_busy); end
    endtask

    task automatic test_random_frames();
        int v0, e0;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            v0 = valid_cnt; e0 = err_cnt;
            send_random_bits(48);
            pulse_latch();
            model_latch(ok);
            n_checks++; if (o_frame !== model_frame) begin n_fail++; $display("FAIL rand_frame[%0d]: got %h want %h", it, o_frame, model_frame); end
            n_checks++; if (valid_cnt - v0 !== (ok ? 1 : 0)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %0d want %0d", it, valid_cnt - v0, ok ? 1 : 0); end
            n_checks++; if (err_cnt - e0 !== (ok ? 0 : 1)) begin n_fail++; $display("FAIL rand_err[%0d]: got %0d want %0d", it, err_cnt - e0, ok ? 0 : 1); end
        end
    endtask

    task automatic test_bad_counts();
        int v0, e0;
        bit ok;
        int counts [5];
        counts = '{0, 1, 40, 47, 50};
        for (int c = 0; c < 5; c++) begin
            v0 = valid_cnt; e0 = err_cnt;
            send_random_bits(counts[c]);
            n_checks++; if (o_busy !== (counts[c] > 0 ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL bad_busy_mid[%0d]: got %b", counts[c], o_busy); end
            pulse_latch();
            model_latch(ok);
            n_checks++; if (err_cnt - e0 !== (ok ? 0 : 1)) begin n_fail++; $display("FAIL bad_err[%0d]: got %0d want %0d", counts[c], err_cnt - e0, ok ? 0 : 1); end
            n_checks++; if (valid_cnt - v0 !== (ok ? 1 : 0)) begin n_fail++; $display("FAIL bad_valid[%0d]: got %0d want %0d", counts[c], valid_cnt - v0, ok ? 1 : 0); end
            n_checks++; if (o_frame !== model_frame) begin n_fail++; $display("FAIL bad_frame_hold[%0d]: got %h want %h", counts[c], o_frame, model_frame); end
            n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bad_busy_after[%0d]: got %b want 0", counts[c], o_busy); end
        end
        v0 = valid_cnt;
        send_random_bits(48);
        pulse_latch();
        model_latch(ok);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL recover_valid: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (o_frame !== model_frame) begin n_fail++; $display("FAIL recover_frame: got %h want %h", o_frame, model_frame); end
    endtask

    task automatic test_timeout();
        int v0, e0, waited, delay;
        bit ok;
        v0 = valid_cnt; e0 = err_cnt;
        // Gaps just under the timeout: each sclk edge must restart the count.
        for (int i = 0; i < 3; i++) begin
            send_random_bits(1);
            tick(TO - 14);
        end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL to_restart_err: got %0d want 0", err_cnt - e0); end
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL to_restart_busy: got %b want 1", o_busy); end
        send_random_bits(17);
        waited = 0;
        while (err_cnt == e0 && waited < TO + 40) begin
            tick(1);
            waited++;
        end
        delay = cyc - last_rise_cyc;
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL to_err: got %0d pulses want 1", err_cnt - e0); end
        n_checks++; if (delay < TO + SYNC || delay > TO + SYNC + 2) begin n_fail++; $display("FAIL to_delay: got %0d cycles want %0d..%0d", delay, TO + SYNC, TO + SYNC + 2); end
        tick(3);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", o_busy); end
        n_checks++; if (o_frame !== model_frame) begin n_fail++; $display("FAIL to_frame_hold: got %h want %h", o_frame, model_frame); end
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL to_valid: got %0d want 0", valid_cnt - v0); end
        sent_q.delete();
        v0 = valid_cnt;
        send_random_bits(48);
        pulse_latch();
        model_latch(ok);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL to_recover_valid: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (o_frame !== model_frame) begin n_fail++; $display("FAIL to_recover_frame: got %h want %h", o_frame, model_frame); end
    endtask

    task automatic test_reset_mid();
        int v0;
        bit ok;
        send_random_bits(24);
        i_rst = 1'b0;
        tick(3);
        model_frame = 48'h0;
        sent_q.delete();
        n_checks++; if (o_frame !== model_frame) begin n_fail++; $display("FAIL rmid_frame: got %h want %h", o_frame, model_frame); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", o_busy); end
        i_rst = 1'b1;
        tick(6);
        v0 = valid_cnt;
        send_random_bits(48);
        pulse_latch();
        model_latch(ok);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rmid_valid: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (o_frame !== model_frame) begin n_fail++; $display("FAIL rmid_new_frame: got %h want %h", o_frame, model_frame); end
    endtask

    task automatic test_same_cycle();
        int v0, e0;
        bit ok, b;
        v0 = valid_cnt; e0 = err_cnt;
        send_random_bits(47);
        b = 1'($urandom_range(1, 0));
        i_sdata = b;
        tick(3);
        i_sclk  = 1'b1;
        i_latch = 1'b1;
        sent_q.push_back(b);
        tick(5);
        i_sclk  = 1'b0;
        i_latch = 1'b0;
        tick(5);
        model_latch(ok);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL same_valid: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL same_err: got %0d want 0", err_cnt - e0); end
        n_checks++; if (o_frame !== model_frame) begin n_fail++; $display("FAIL same_frame: got %h want %h", o_frame, model_frame); end
    endtask

    task automatic test_release_levels();
        int e0;
        i_rst = 1'b0;
        i_sclk = 1'b1;
        i_latch = 1'b1;
        tick(3);
        e0 = err_cnt;
        i_rst = 1'b1;
        tick(10);
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL levels_err: got %0d want 0", err_cnt - e0); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL levels_busy: got %b want 0", o_busy); end
        i_sclk = 1'b0;
        i_latch = 1'b0;
        tick(6);
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL levels_fall_err: got %0d want 0", err_cnt - e0); end
        model_frame = 48'h0;
        sent_q.delete();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_random_frames();
        test_bad_counts();
        test_timeout();
        test_reset_mid();
        test_same_cycle();
        test_release_levels();
        test_random_frames();
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_err_overlap: got %0d cycles want 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
